video_address_gen: RTL and testbench

Display address generator for the VDG core. Sits directly upstream of the display data fetch and character-row lookup, and is driven by the frame timing block's strobes. It turns the per-byte fetch strobe and line/frame syncs into the 13-bit display address `da`, the character-row index `alpha_row` and the row-preset pulse `rp`. Line repetition and line width follow the selected alpha/graphics mode.

---
 rtl/vdg_pkg.sv | 41 ++++
 rtl/line_edge_detect.sv | 30 +++
 rtl/video_address_gen.sv | 115 +++++++++++
 tb/tb_video_address_gen.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdg_pkg.sv
// rtl/vdg_pkg.sv - shared VDG constants, line geometry type and mode geometry lookup
package vdg_pkg;

  localparam int VDG_ADDR_W = 13;

  // Bytes fetched per display line and how many scan lines repeat each row
  typedef struct packed {
    logic [5:0] bytes;
    logic [3:0] reps;
  } geom_t;

  localparam logic [5:0] B_NARROW = 6'd16;
  localparam logic [5:0] B_WIDE   = 6'd32;

  localparam logic [3:0] R_ALPHA  = 4'd12;
  localparam logic [3:0] R_TRIPLE = 4'd3;
  localparam logic [3:0] R_DOUBLE = 4'd2;
  localparam logic [3:0] R_SINGLE = 4'd1;

  localparam logic [3:0] ALPHA_ROW_LAST = 4'd11;

  localparam geom_t GEOM_ALPHA = '{bytes: B_WIDE, reps: R_ALPHA};

  function automatic geom_t mode_geometry(input logic ang, input logic [2:0] gm);
    geom_t g;
    if (!ang) begin
      g = GEOM_ALPHA;
    end else begin
      case (gm)
        3'd0, 3'd1: g = '{bytes: B_NARROW, reps: R_TRIPLE};
        3'd2:       g = '{bytes: B_WIDE,   reps: R_TRIPLE};
        3'd3:       g = '{bytes: B_NARROW, reps: R_DOUBLE};
        3'd4:       g = '{bytes: B_WIDE,   reps: R_DOUBLE};
        3'd5:       g = '{bytes: B_NARROW, reps: R_SINGLE};
        default:    g = '{bytes: B_WIDE,   reps: R_SINGLE};
      endcase
    end
    return g;
  endfunction

endpackage

// File: rtl/line_edge_detect.sv
// rtl/line_edge_detect.sv - registered falling-edge pulse of the active-low line sync
module line_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic hsn,
  output logic boundary
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d  = hsn;
    sync2_d  = sync1_q;
    // Pulse lands one cycle after hsn is first sampled low
    boundary = sync2_q & ~sync1_q;
  end

  // Idle level is high so a reset never looks like a falling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

endmodule

// File: rtl/video_address_gen.sv
// rtl/video_address_gen.sv - display byte address, character row and row preset generator
module video_address_gen
  import vdg_pkg::*;
#(
  parameter int ADDR_W = VDG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fsn,
  input  logic              hsn,
  input  logic              preload,
  input  logic              ang,
  input  logic [2:0]        gm,
  output logic [ADDR_W-1:0] da,
  output logic [3:0]        alpha_row,
  output logic              rp
);

  logic [ADDR_W-1:0] da_q, da_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [5:0]        byte_cnt_q, byte_cnt_d;
  logic [3:0]        rep_cnt_q, rep_cnt_d;
  logic [3:0]        alpha_row_q, alpha_row_d;
  logic              rp_q, rp_d;
  geom_t             geom_q, geom_d;
  logic              alpha_mode_q, alpha_mode_d;

  logic              boundary;
  geom_t             geom_now;
  logic [ADDR_W-1:0] row_next;

  line_edge_detect u_line_edge_detect (
    .clk      (clk),
    .rst      (reset),
    .hsn      (hsn),
    .boundary (boundary)
  );

  always_comb begin
    da_d         = da_q;
    row_base_d   = row_base_q;
    byte_cnt_d   = byte_cnt_q;
    rep_cnt_d    = rep_cnt_q;
    alpha_row_d  = alpha_row_q;
    rp_d         = 1'b0;
    geom_d       = geom_q;
    alpha_mode_d = alpha_mode_q;

    geom_now = mode_geometry(ang, gm);
    row_next = row_base_q + ADDR_W'(geom_q.bytes);

    if (!fsn) begin
      da_d         = '0;
      row_base_d   = '0;
      byte_cnt_d   = '0;
      rep_cnt_d    = '0;
      alpha_row_d  = '0;
      geom_d       = geom_now;
      alpha_mode_d = ~ang;
    end else if (boundary) begin
      // Geometry of the line just finished drives this update; the new one applies next line
      geom_d       = geom_now;
      alpha_mode_d = ~ang;
      if (byte_cnt_q != 6'd0) begin
        byte_cnt_d = '0;
        if (rep_cnt_q < geom_q.reps - 4'd1) begin
          da_d      = row_base_q;
          rep_cnt_d = rep_cnt_q + 4'd1;
        end else begin
          row_base_d = row_next;
          da_d       = row_next;
          rep_cnt_d  = '0;
        end
        if (alpha_mode_q) begin
          if (alpha_row_q == ALPHA_ROW_LAST) begin
            alpha_row_d = '0;
            rp_d        = 1'b1;
          end else begin
            alpha_row_d = alpha_row_q + 4'd1;
          end
        end
      end
    end else if (preload && (byte_cnt_q < geom_q.bytes)) begin
      da_d       = da_q + ADDR_W'(1);
      byte_cnt_d = byte_cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      da_q         <= '0;
      row_base_q   <= '0;
      byte_cnt_q   <= '0;
      rep_cnt_q    <= '0;
      alpha_row_q  <= '0;
      rp_q         <= 1'b0;
      geom_q       <= GEOM_ALPHA;
      alpha_mode_q <= 1'b1;
    end else begin
      da_q         <= da_d;
      row_base_q   <= row_base_d;
      byte_cnt_q   <= byte_cnt_d;
      rep_cnt_q    <= rep_cnt_d;
      alpha_row_q  <= alpha_row_d;
      rp_q         <= rp_d;
      geom_q       <= geom_d;
      alpha_mode_q <= alpha_mode_d;
    end
  end

  assign da        = da_q;
  assign alpha_row = alpha_row_q;
  assign rp        = rp_q;

endmodule

// File: tb/tb_video_address_gen.sv
// tb/tb_video_address_gen.sv - self-checking bench for video_address_gen against a line-level model
module tb_video_address_gen;

  localparam int AW = 13;
  localparam int AMOD = 8192;

  logic          clk = 1'b0;
  logic          reset;
  logic          fsn;
  logic          hsn;
  logic          preload;
  logic          ang;
  logic [2:0]    gm;
  logic [AW-1:0] da;
  logic [3:0]    alpha_row;
  logic          rp;

  int n_cmp = 0;
  int n_fail = 0;

  // Line-level reference model state
  int m_da, m_base, m_bytes, m_rep, m_row, m_b, m_r, m_rp;
  bit m_alpha;
  int tb_b [8] = '{16, 16, 32, 16, 32, 16, 32, 32};
  int tb_r [8] = '{3, 3, 3, 2, 2, 1, 1, 1};

  video_address_gen #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .fsn       (fsn),
    .hsn       (hsn),
    .preload   (preload),
    .ang       (ang),
    .gm        (gm),
    .da        (da),
    .alpha_row (alpha_row),
    .rp        (rp)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_da = 0; m_base = 0; m_bytes = 0; m_rep = 0; m_row = 0; m_rp = 0;
    m_b = 32; m_r = 12; m_alpha = 1;
  endtask

  task automatic model_latch();
    if (!ang) begin
      m_b = 32; m_r = 12; m_alpha = 1;
    end else begin
      m_b = tb_b[gm]; m_r = tb_r[gm]; m_alpha = 0;
    end
  endtask

  task automatic model_boundary();
    m_rp = 0;
    if (m_bytes != 0) begin
      if (m_rep < m_r - 1) begin
        m_da = m_base;
        m_rep++;
      end else begin
        m_base = (m_base + m_b) % AMOD;
        m_da = m_base;
        m_rep = 0;
      end
      if (m_alpha) begin
        m_row++;
        if (m_row == 12) begin
          m_row = 0;
          m_rp = 1;
        end
      end
      m_bytes = 0;
    end
    model_latch();
  endtask

  task automatic set_mode(input logic a, input logic [2:0] g);
    ang = a;
    gm = g;
  endtask

  task automatic frame_clear();
    fsn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (rp !== 1'b0 || da !== '0 || alpha_row !== 4'd0) begin
        n_fail++;
        $display("FAIL frame_clear_outputs: da=%0d alpha_row=%0d rp=%0b required 0/0/0", da, alpha_row, rp);
      end
    end
    fsn = 1'b1;
    @(negedge clk);
    m_da = 0; m_base = 0; m_bytes = 0; m_rep = 0; m_row = 0; m_rp = 0;
    model_latch();
  endtask

  task automatic send_bytes(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      preload = 1'b1;
      @(negedge clk);
      preload = 1'b0;
      if (m_bytes < m_b) begin
        m_da = (m_da + 1) % AMOD;
        m_bytes++;
      end
      if (gaps && $urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic hsync(output int rpc);
    rpc = 0;
    hsn = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rp === 1'b1) rpc++;
    end
    hsn = 1'b1;
    repeat (3) @(negedge clk);
    model_boundary();
  endtask

  task automatic test_reset();
    reset = 1'b1; fsn = 1'b1; hsn = 1'b1; preload = 1'b0; ang = 1'b0; gm = 3'd0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (da !== '0) begin n_fail++; $display("FAIL reset_da: got %0d required 0", da); end
    n_cmp++;
    if (alpha_row !== 4'd0) begin n_fail++; $display("FAIL reset_alpha_row: got %0d required 0", alpha_row); end
    n_cmp++;
    if (rp !== 1'b0) begin n_fail++; $display("FAIL reset_rp: got %0b required 0", rp); end
    reset = 1'b0;
    @(negedge clk);
    model_reset();
  endtask

  task automatic test_gm6_lines();
    int rpc;
    set_mode(1'b1, 3'd6);
    frame_clear();
    preload = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (da !== 13'd1) begin n_fail++; $display("FAIL preload_latency_da: got %0d required 1", da); end
    @(negedge clk);
    preload = 1'b0;
    m_da = 1; m_bytes = 1;
    send_bytes(31, 1'b0);
    for (int l = 1; l <= 3; l++) begin
      if (l > 1) send_bytes(32, 1'b1);
      hsync(rpc);
      n_cmp++;
      if (da !== 13'(m_da) || da !== 13'(32 * l)) begin
        n_fail++; $display("FAIL gm6_line%0d_da: got %0d required %0d", l, da, 32 * l);
      end
      n_cmp++;
      if (alpha_row !== 4'd0) begin n_fail++; $display("FAIL gm6_alpha_row: got %0d required 0", alpha_row); end
    end
    frame_clear();
    n_cmp++;
    if (da !== '0) begin n_fail++; $display("FAIL gm6_after_clear_da: got %0d required 0", da); end
  endtask

  task automatic test_gm0_repeat();
    int rpc;
    int exp_da [4] = '{0, 0, 16, 32};
    set_mode(1'b1, 3'd0);
    frame_clear();
    for (int l = 0; l < 4; l++) begin
      send_bytes(16, 1'b1);
      if (l == 3) begin
        n_cmp++;
        if (da !== 13'(exp_da[3]) || da !== 13'(m_da)) begin
          n_fail++; $display("FAIL gm0_line4_end_da: got %0d required %0d", da, exp_da[3]);
        end
      end else begin
        hsync(rpc);
        n_cmp++;
        if (da !== 13'(exp_da[l]) || da !== 13'(m_da)) begin
          n_fail++; $display("FAIL gm0_line%0d_da: got %0d required %0d", l + 1, da, exp_da[l]);
        end
      end
    end
  endtask

  task automatic test_alpha_rows();
    int rpc;
    set_mode(1'b0, 3'd0);
    frame_clear();
    for (int l = 1; l <= 13; l++) begin
      send_bytes(32, 1'b0);
      hsync(rpc);
      n_cmp++;
      if (alpha_row !== 4'(m_row) || alpha_row !== 4'(l % 12)) begin
        n_fail++; $display("FAIL alpha_row_line%0d: got %0d required %0d", l, alpha_row, l % 12);
      end
      n_cmp++;
      if (rpc !== m_rp) begin
        n_fail++; $display("FAIL alpha_rp_line%0d: got %0d pulses required %0d", l, rpc, m_rp);
      end
      if (l == 12) begin
        n_cmp++;
        if (da !== 13'd32) begin n_fail++; $display("FAIL alpha_da_after_wrap: got %0d required 32", da); end
      end
    end
  endtask

  task automatic test_overrun();
    set_mode(1'b1, 3'd5);
    frame_clear();
    send_bytes(40, 1'b1);
    n_cmp++;
    if (da !== 13'd16 || da !== 13'(m_da)) begin
      n_fail++; $display("FAIL gm5_overrun_da: got %0d required 16", da);
    end
  endtask

  task automatic test_boundary_drop();
    int rpc;
    set_mode(1'b1, 3'd6);
    frame_clear();
    send_bytes(5, 1'b0);
    hsn = 1'b0;
    @(negedge clk);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    hsn = 1'b1;
    repeat (3) @(negedge clk);
    model_boundary();
    n_cmp++;
    if (da !== 13'd32 || da !== 13'(m_da)) begin
      n_fail++; $display("FAIL boundary_drop_da: got %0d required 32", da);
    end
    set_mode(1'b0, 3'd0);
    hsync(rpc);
    hsync(rpc);
    n_cmp++;
    if (da !== 13'd32 || alpha_row !== 4'd0) begin
      n_fail++; $display("FAIL blank_lines_state: da=%0d alpha_row=%0d required 32/0", da, alpha_row);
    end
    send_bytes(3, 1'b0);
    hsync(rpc);
    n_cmp++;
    if (alpha_row !== 4'(m_row) || da !== 13'(m_da)) begin
      n_fail++; $display("FAIL blank_then_alpha: da=%0d row=%0d required %0d/%0d", da, alpha_row, m_da, m_row);
    end
  endtask

  task automatic test_reset_mid_line();
    set_mode(1'b0, 3'd0);
    send_bytes(7, 1'b0);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (da !== '0 || alpha_row !== 4'd0 || rp !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_outputs: da=%0d row=%0d rp=%0b required 0/0/0", da, alpha_row, rp);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    model_reset();
    send_bytes(3, 1'b0);
    n_cmp++;
    if (da !== 13'd3 || da !== 13'(m_da)) begin
      n_fail++; $display("FAIL resume_after_reset_da: got %0d required 3", da);
    end
  endtask

  task automatic test_wrap();
    int rpc;
    set_mode(1'b1, 3'd7);
    frame_clear();
    for (int l = 0; l < 255; l++) begin
      send_bytes(32, 1'b0);
      hsync(rpc);
    end
    send_bytes(31, 1'b0);
    n_cmp++;
    if (da !== 13'd8191) begin n_fail++; $display("FAIL wrap_da_top: got %0d required 8191", da); end
    send_bytes(1, 1'b0);
    n_cmp++;
    if (da !== 13'd0 || da !== 13'(m_da)) begin n_fail++; $display("FAIL wrap_da_zero: got %0d required 0", da); end
    hsync(rpc);
    n_cmp++;
    if (da !== 13'd0) begin n_fail++; $display("FAIL wrap_row_base: got %0d required 0", da); end
    send_bytes(5, 1'b0);
    n_cmp++;
    if (da !== 13'd5) begin n_fail++; $display("FAIL wrap_next_line_da: got %0d required 5", da); end
  endtask

  task automatic test_random();
    int rpc;
    int nl;
    for (int f = 0; f < 6; f++) begin
      set_mode(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      frame_clear();
      nl = $urandom_range(3, 10);
      for (int l = 0; l < nl; l++) begin
        send_bytes($urandom_range(0, 40), 1'b1);
        n_cmp++;
        if (da !== 13'(m_da)) begin
          n_fail++; $display("FAIL rand_f%0d_l%0d_end_da: got %0d required %0d", f, l, da, m_da);
        end
        if ($urandom_range(0, 3) == 0) set_mode(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        hsync(rpc);
        n_cmp++;
        if (da !== 13'(m_da) || alpha_row !== 4'(m_row) || rpc !== m_rp) begin
          n_fail++;
          $display("FAIL rand_f%0d_l%0d_boundary: da=%0d row=%0d rp=%0d required %0d/%0d/%0d",
                   f, l, da, alpha_row, rpc, m_da, m_row, m_rp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_gm6_lines();
    test_gm0_repeat();
    test_alpha_rows();
    test_overrun();
    test_boundary_drop();
    test_reset_mid_line();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
